// File: rtl/rca_stim_checker_pkg.sv
// rca_chk_pkg: shared FSM state type and parameter sanity limits for the
// ripple-carry adder stimulus checker.
package rca_chk_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_t;
  localparam int MIN_N = 1;
  localparam int MIN_SETTLE = 1;
  function automatic int cnt_width(input int settle);
    return settle > 1 ? $clog2(settle) : 1;
  endfunction
endpackage

// File: rtl/rca_stim_checker_if.sv
// rca_stim_checker_if: adder port bundle.
//   A, B, Cin : operands toward the adder
//   SUM, Cout : adder result back to the checker
//   master = checker side, slave = adder side
interface rca_stim_checker_if #(parameter int N = 2);
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic [N-1:0] SUM;
  logic         Cout;
  modport master (output A, B, Cin, input SUM, Cout);
  modport slave (input A, B, Cin, output SUM, Cout);
endinterface

// File: rtl/rca_stim_checker_golden.sv
// rca_golden: combinational reference sum A+B+Cin at N+1 bits.
//   A, B : N-bit operands, Cin : carry-in, o_sum : {carry, sum}
module rca_golden #(parameter int N = 2) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N:0]   o_sum
);
  assign o_sum = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, Cin};
endmodule

// File: rtl/rca_stim_checker.sv
// rca_stim_checker: exhaustive stimulus sweep and result check of an N-bit adder.
//   clk, rst_n      : clock, async active-low reset
//   start, abort    : begin a sweep (IDLE/DONE only), cancel a running sweep
//   adder           : master side of the adder bus (A/B/Cin out, SUM/Cout in)
//   busy, done, pass: sweep running, sweep finished, finished with no errors
//   err_count       : saturating mismatch count
//   first_err_*     : {A,B,Cin} of the first mismatch and its valid flag
module rca_stim_checker
  import rca_chk_pkg::*;
#(
  parameter int N      = 2,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  rca_stim_checker_if.master  adder,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count,
  output logic                first_err_valid,
  output logic [2*N:0]        first_err_vec
);
  localparam int CW = cnt_width(SETTLE);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);
  if (SETTLE < MIN_SETTLE || N < MIN_N) begin : g_bad_param
    $error("rca_stim_checker: SETTLE and N must be at least 1");
  end
  state_t           r_state;
  logic [2*N:0]     r_vec;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [ERR_W-1:0] r_err;
  logic             r_fev_valid;
  logic [2*N:0]     r_fev;
  logic [N:0]       w_ref;
  logic             w_mis;
  rca_golden #(.N(N)) u_golden (
    .A     (r_vec[2*N:N+1]),
    .B     (r_vec[N:1]),
    .Cin   (r_vec[0]),
    .o_sum (w_ref)
  );
  // Cin is the vector LSB so it toggles fastest, then B, then A.
  assign adder.A         = r_vec[2*N:N+1];
  assign adder.B         = r_vec[N:1];
  assign adder.Cin       = r_vec[0];
  assign w_mis           = {adder.Cout, adder.SUM} != w_ref;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_done & ~|r_err;
  assign err_count       = r_err;
  assign first_err_valid = r_fev_valid;
  assign first_err_vec   = r_fev;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_vec       <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= '0;
      r_fev_valid <= 1'b0;
      r_fev       <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state     <= ST_SETTLE;
            r_vec       <= '0;
            r_cnt       <= CNT_LOAD;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= '0;
            r_fev_valid <= 1'b0;
            r_fev       <= '0;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state <= ST_CHECK;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_CHECK: begin
          // abort outranks the compare, including the final vector's
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            if (w_mis) begin
              r_err <= &r_err ? r_err : r_err + 1'b1;
              if (!r_fev_valid) begin
                r_fev_valid <= 1'b1;
                r_fev       <= r_vec;
              end
            end
            if (&r_vec) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_SETTLE;
              r_vec   <= r_vec + 1'b1;
              r_cnt   <= CNT_LOAD;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
